// File: rtl/dual_ram_fwd.sv
// Simple dual-port RAM with byte strobes, same-cycle write-to-read forwarding,
// 1- or 2-cycle read latency and an optional post-reset zero-fill sequencer.
module dual_ram_fwd #(
  parameter int DW             = 32,
  parameter int AW             = 12,
  parameter int MEM_NUM        = 4096,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_en,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  input  logic            r_en,
  input  logic [AW-1:0]   r_addr_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_valid_o,
  output logic            init_busy_o
);

  localparam int NB = DW / 8;
  localparam int IW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [AW:0] MEM_NUM_W = (AW+1)'(MEM_NUM);
  localparam logic [AW:0] LAST_W    = (AW+1)'(MEM_NUM - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_reg;
  logic [AW:0]   cnt_reg;
  logic          busy_reg;

  // Counter is one bit wider than the address so MEM_NUM = 2^AW still terminates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_reg   <= '0;
      busy_reg  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_reg)
        CLEAR: begin
          cnt_reg <= cnt_reg + (AW+1)'(1);
          if (cnt_reg == LAST_W) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy_o = busy_reg;

  logic          clearing;
  logic          idle;
  logic          w_in_range;
  logic          r_in_range;
  logic          wr_go;
  logic          rd_go;
  logic          fwd_hit;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign clearing   = (state_reg == CLEAR);
  assign idle       = (state_reg == IDLE);
  assign w_in_range = ({1'b0, w_addr_i} < MEM_NUM_W);
  assign r_in_range = ({1'b0, r_addr_i} < MEM_NUM_W);
  assign wr_go      = idle && w_en && w_in_range;
  assign rd_go      = idle && r_en;
  assign fwd_hit    = wr_go && (w_addr_i == r_addr_i);
  assign wr_idx     = clearing ? cnt_reg[IW-1:0] : w_addr_i[IW-1:0];
  assign rd_idx     = r_addr_i[IW-1:0];

  logic [DW-1:0] s1_data;
  logic          s1_valid_reg;

  // One narrow array per byte lane keeps strobed writes a plain lane write-enable.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [MEM_NUM];
    logic [7:0] rd_byte_reg;
    logic       wr_lane;

    assign wr_lane = clearing || (wr_go && w_strb_i[gi]);

    always_ff @(posedge clk) begin
      if (wr_lane) begin
        mem[wr_idx] <= clearing ? 8'h00 : w_data_i[8*gi +: 8];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_byte_reg <= 8'h00;
      end else if (rd_go) begin
        if (!r_in_range) begin
          rd_byte_reg <= 8'h00;
        end else if (fwd_hit && w_strb_i[gi]) begin
          rd_byte_reg <= w_data_i[8*gi +: 8];
        end else begin
          rd_byte_reg <= mem[rd_idx];
        end
      end
    end

    assign s1_data[8*gi +: 8] = rd_byte_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= rd_go;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] s2_data_reg;
    logic          s2_valid_reg;

    // Second stage only captures completed reads so the output holds between results.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s2_data_reg  <= '0;
        s2_valid_reg <= 1'b0;
      end else begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_data_reg <= s1_data;
        end
      end
    end

    assign r_data_o  = s2_data_reg;
    assign r_valid_o = s2_valid_reg;
  end else begin : g_no_out_reg
    assign r_data_o  = s1_data;
    assign r_valid_o = s1_valid_reg;
  end

endmodule

// File: tb/tb_dual_ram_fwd.sv
// Scoreboard bench: two instances (1-cycle/16 words, 2-cycle/12 words) share
// randomized and directed stimulus and are checked against a word-level model.
module tb_dual_ram_fwd;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_en = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [NB-1:0] w_strb = '0;
  logic          r_en = 1'b0;
  logic [AW-1:0] r_addr = '0;

  logic [DW-1:0] rdata  [2];
  logic          rvalid [2];
  logic          busy   [2];

  always #5 clk = ~clk;

  dual_ram_fwd #(.DW(DW), .AW(AW), .MEM_NUM(16), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .r_en(r_en), .r_addr_i(r_addr), .r_data_o(rdata[0]),
    .r_valid_o(rvalid[0]), .init_busy_o(busy[0])
  );

  dual_ram_fwd #(.DW(DW), .AW(AW), .MEM_NUM(12), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_strb_i(w_strb), .r_en(r_en), .r_addr_i(r_addr), .r_data_o(rdata[1]),
    .r_valid_o(rvalid[1]), .init_busy_o(busy[1])
  );

  function automatic int mem_num(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int extra_lat(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t          sbq [2][$];
  logic [DW-1:0] mdl [2][16];
  int            clear_left [2];
  logic [DW-1:0] last_out [2];
  int            cyc   = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  // Reference model: each accepted read predicts its word and the cycle it is due.
  always @(posedge clk) begin : model
    exp_t e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        clear_left[k] = mem_num(k);
        sbq[k].delete();
        for (int i = 0; i < 16; i++) mdl[k][i] = '0;
      end else if (clear_left[k] > 0) begin
        clear_left[k]--;
      end else begin
        if (r_en) begin
          e.d = '0;
          if (int'(r_addr) < mem_num(k)) begin
            for (int b = 0; b < NB; b++) begin
              e.d[8*b +: 8] = (w_en && w_addr == r_addr && w_strb[b]) ?
                              w_data[8*b +: 8] : mdl[k][r_addr][8*b +: 8];
            end
          end
          e.due = cyc + extra_lat(k);
          sbq[k].push_back(e);
        end
        if (w_en && int'(w_addr) < mem_num(k)) begin
          for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) mdl[k][w_addr][8*b +: 8] = w_data[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got %h, want %h", nm, k, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t h;
    logic exp_v;
    for (int k = 0; k < 2; k++) begin
      while (sbq[k].size() > 0 && sbq[k][0].due < cyc) begin
        h = sbq[k].pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_read dut%0d cycle %0d: got none, want %h due %0d", k, cyc, h.d, h.due);
      end
      exp_v = (sbq[k].size() > 0) && (sbq[k][0].due == cyc);
      chk("r_valid", k, {31'd0, rvalid[k]}, {31'd0, exp_v});
      if (exp_v) begin
        h = sbq[k].pop_front();
        last_out[k] = h.d;
      end
      chk("r_data", k, rdata[k], last_out[k]);
      chk("init_busy", k, {31'd0, busy[k]}, {31'd0, (clear_left[k] > 0)});
    end
  end

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] ws, input logic re, input logic [AW-1:0] ra);
    w_en = we; w_addr = wa; w_data = wd; w_strb = ws; r_en = re; r_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sbq[k].delete();
      last_out[k]   = '0;
      clear_left[k] = mem_num(k);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic random_traffic(input int n);
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    for (int i = 0; i < n; i++) begin
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 1) ? wa : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ra);
    end
  endtask

  initial begin
    do_reset();
    // Requests inside the clear window must be dropped.
    repeat (8) drive(1'b1, 4'h3, 32'h12345678, 4'hF, 1'b1, 4'h3);
    idle(12);
    for (int a = 0; a < 16; a++) drive(1'b0, '0, '0, '0, 1'b1, 4'(a));
    idle(2);
    drive(1'b1, 4'h5, 32'hAABBCCDD, 4'hF, 1'b0, '0);
    drive(1'b1, 4'h5, 32'h11223344, 4'h5, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'h5);
    idle(2);
    drive(1'b1, 4'h7, 32'hDEADBEEF, 4'h3, 1'b1, 4'h7);
    drive(1'b0, '0, '0, '0, 1'b1, 4'h7);
    drive(1'b1, 4'h8, 32'hCAFEF00D, 4'hF, 1'b1, 4'h9);
    idle(2);
    for (int a = 0; a < 4; a++) drive(1'b1, 4'(a), 32'(10 + a), 4'hF, 1'b0, '0);
    for (int a = 0; a < 4; a++) drive(1'b0, '0, '0, '0, 1'b1, 4'(a));
    idle(3);
    drive(1'b1, 4'hE, 32'h5A5A5A5A, 4'hF, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'hE);
    idle(3);
    // A write right behind a read must not alter the result still in flight.
    drive(1'b0, '0, '0, '0, 1'b1, 4'h2);
    drive(1'b1, 4'h2, 32'hFFFFFFFF, 4'hF, 1'b1, 4'h2);
    idle(3);
    random_traffic(300);
    drive(1'b0, '0, '0, '0, 1'b1, 4'h4);
    do_reset();
    repeat (4) drive(1'b1, 4'h4, 32'h87654321, 4'hF, 1'b1, 4'h4);
    idle(14);
    random_traffic(150);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
